// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready on the operand side
// and on the result side, plus the registered result and flags.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [3:0]       alucontrol;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] aluresult;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, srca, srcb, alucontrol, out_ready,
        input  in_ready, out_valid, aluresult, zero, carry, ovf, err
    );

    modport slave (
        input  in_valid, srca, srcb, alucontrol, out_ready,
        output in_ready, out_valid, aluresult, zero, carry, ovf, err
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add/sub, iterative shift-add multiply and
// restoring divide. Define ALU_DIV_EN to build the divider (divu/remu); otherwise they are illegal.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             err_reg;
`ifdef ALU_DIV_EN
    logic             is_mul_reg;
    logic             is_rem_reg;
`endif

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   inv_amt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_err;
    logic             sc_multi;

    // Single-cycle datapath, evaluated straight from the operands being offered.
    always_comb begin
        sum_ext   = {1'b0, bus.srca} + {1'b0, bus.srcb};
        diff_ext  = {1'b0, bus.srca} - {1'b0, bus.srcb};
        amt       = bus.srcb[SHW-1:0];
        inv_amt   = ~amt + SHW'(1);
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_ovf    = 1'b0;
        sc_err    = 1'b0;
        sc_multi  = 1'b0;
        case (bus.alucontrol)
            4'b0000: begin
                sc_result = sum_ext[WIDTH-1:0];
                sc_carry  = sum_ext[WIDTH];
                sc_ovf    = (bus.srca[WIDTH-1] == bus.srcb[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.srca[WIDTH-1]);
            end
            4'b0001: sc_result = bus.srca | bus.srcb;
            4'b0010: sc_result = bus.srca & bus.srcb;
            4'b0011: sc_result = bus.srca ^ bus.srcb;
            4'b0100: sc_result = ~(bus.srca | bus.srcb);
            4'b0101: sc_result = bus.srca << amt;
            // inv_amt wraps to 0 for amt==0, so both halves are srca and the OR returns srca
            4'b0110: sc_result = (bus.srca << amt) | (bus.srca >> inv_amt);
            4'b0111: begin
                sc_result = diff_ext[WIDTH-1:0];
                sc_carry  = diff_ext[WIDTH];
                sc_ovf    = (bus.srca[WIDTH-1] != bus.srcb[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != bus.srca[WIDTH-1]);
            end
            4'b1000: sc_multi = 1'b1;
`ifdef ALU_DIV_EN
            4'b1001: begin
                if (bus.srcb == '0) begin
                    sc_result = '1;
                    sc_err    = 1'b1;
                end else begin
                    sc_multi  = 1'b1;
                end
            end
            4'b1010: begin
                if (bus.srcb == '0) begin
                    sc_result = bus.srca;
                    sc_err    = 1'b1;
                end else begin
                    sc_multi  = 1'b1;
                end
            end
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // Iterative datapath. mul: acc accumulates, opa is the shifting multiplicand,
    // opb the shifting multiplier. div: acc is the partial remainder, opa shifts the
    // dividend out of its top while quotient bits enter at the bottom, opb is the divisor.
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] busy_result;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
`endif

    always_comb begin
        mul_acc_next = acc_reg + (opb_reg[0] ? opa_reg : '0);
`ifdef ALU_DIV_EN
        div_shift    = {acc_reg, opa_reg[WIDTH-1]};
        div_ge       = (div_shift >= {1'b0, opb_reg});
        // When the trial subtraction succeeds the difference is below the divisor,
        // so the WIDTH-bit subtraction is exact.
        rem_next     = div_ge ? (div_shift[WIDTH-1:0] - opb_reg) : div_shift[WIDTH-1:0];
        q_next       = {opa_reg[WIDTH-2:0], div_ge};
        busy_result  = is_mul_reg ? mul_acc_next : (is_rem_reg ? rem_next : q_next);
`else
        busy_result  = mul_acc_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            acc_reg       <= '0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            err_reg       <= 1'b0;
`ifdef ALU_DIV_EN
            is_mul_reg    <= 1'b0;
            is_rem_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_reg <= 1'b0;
                        if (sc_multi) begin
                            state_reg  <= BUSY;
                            count_reg  <= CW'(WIDTH);
                            acc_reg    <= '0;
                            opa_reg    <= bus.srca;
                            opb_reg    <= bus.srcb;
`ifdef ALU_DIV_EN
                            is_mul_reg <= (bus.alucontrol == 4'b1000);
                            is_rem_reg <= (bus.alucontrol == 4'b1010);
`endif
                        end else begin
                            state_reg     <= DONE;
                            out_valid_reg <= 1'b1;
                            result_reg    <= sc_result;
                            zero_reg      <= (sc_result == '0);
                            carry_reg     <= sc_carry;
                            ovf_reg       <= sc_ovf;
                            err_reg       <= sc_err;
                        end
                    end
                end
                BUSY: begin
                    count_reg <= count_reg - CW'(1);
`ifdef ALU_DIV_EN
                    if (is_mul_reg) begin
                        acc_reg <= mul_acc_next;
                        opa_reg <= opa_reg << 1;
                        opb_reg <= opb_reg >> 1;
                    end else begin
                        acc_reg <= rem_next;
                        opa_reg <= q_next;
                    end
`else
                    acc_reg <= mul_acc_next;
                    opa_reg <= opa_reg << 1;
                    opb_reg <= opb_reg >> 1;
`endif
                    if (count_reg == CW'(1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= busy_result;
                        zero_reg      <= (busy_result == '0);
                        carry_reg     <= 1'b0;
                        ovf_reg       <= 1'b0;
                        err_reg       <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.aluresult = result_reg;
    assign bus.zero      = zero_reg;
    assign bus.carry     = carry_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed vector table, reset/hold/back-to-back sequences,
// and random operations checked against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;   // {zero, carry, ovf, err}
        int           lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [3:0] flg, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.lat = lat;
        return v;
    endfunction

    // Reference model computed with wide integer arithmetic.
    function automatic vec_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t        v;
        longint      sa, sb, s;
        logic [63:0] p;
        int          sh;
        logic        c, o, e;
        v.op = op; v.a = a; v.b = b; v.res = '0; v.lat = 1;
        c = 1'b0; o = 1'b0; e = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        sh = int'(b % 32);
        case (op)
            4'd0: begin
                p = 64'(a) + 64'(b);
                v.res = p[31:0];
                c = p[32];
                s = sa + sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: v.res = a | b;
            4'd2: v.res = a & b;
            4'd3: v.res = a ^ b;
            4'd4: v.res = ~(a | b);
            4'd5: v.res = a << sh;
            4'd6: begin
                v.res = a;
                for (int i = 0; i < sh; i++) v.res = {v.res[W-2:0], v.res[W-1]};
            end
            4'd7: begin
                v.res = a - b;
                c = (a < b);
                s = sa - sb;
                o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd8: begin
                p = 64'(a) * 64'(b);
                v.res = p[31:0];
                v.lat = 33;
            end
`ifdef ALU_DIV_EN
            4'd9: begin
                if (b == 0) begin v.res = '1; e = 1'b1; end
                else begin v.res = a / b; v.lat = 33; end
            end
            4'd10: begin
                if (b == 0) begin v.res = a; e = 1'b1; end
                else begin v.res = a % b; v.lat = 33; end
            end
`endif
            default: e = 1'b1;
        endcase
        v.flg = {(v.res == 0), c, o, e};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // One full transaction: wait for in_ready, offer, wait for out_valid, hand-shake result.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] res, output logic [3:0] flg, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
        bus.srca = a; bus.srcb = b; bus.alucontrol = op; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.srca = $urandom(); bus.srcb = $urandom(); bus.alucontrol = 4'($urandom());
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.aluresult;
        flg = {bus.zero, bus.carry, bus.ovf, bus.err};
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    logic [W-1:0] res, hold_res;
    logic [3:0]   flg;
    int           lat;
    vec_t         e;
    vec_t         exp_q[$];
    int           accepts;
    int           saw_valid;

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.srca = '0; bus.srcb = '0; bus.alucontrol = '0;

        vecs.push_back(mk(4'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1100, 1));
        vecs.push_back(mk(4'h7, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0010, 1));
        vecs.push_back(mk(4'h6, 32'h80000001, 32'h21,       32'h00000003, 4'b0000, 1));
        vecs.push_back(mk(4'h5, 32'h1,        32'd31,       32'h80000000, 4'b0000, 1));
        vecs.push_back(mk(4'h6, 32'h12345678, 32'h0,        32'h12345678, 4'b0000, 1));
        vecs.push_back(mk(4'h8, 32'h10000,    32'h10001,    32'h00010000, 4'b0000, 33));
        vecs.push_back(mk(4'hF, 32'h5,        32'h3,        32'h0,        4'b1001, 1));
        vecs.push_back(mk(4'hB, 32'h0,        32'h0,        32'h0,        4'b1001, 1));
        vecs.push_back(mk(4'h1, 32'hF0F00000, 32'h0F0F0000, 32'hFFFF0000, 4'b0000, 1));
        vecs.push_back(mk(4'h2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505, 4'b0000, 1));
        vecs.push_back(mk(4'h3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA, 4'b0000, 1));
        vecs.push_back(mk(4'h4, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0000, 1));
        vecs.push_back(mk(4'h7, 32'h3,        32'h5,        32'hFFFFFFFE, 4'b0100, 1));
        vecs.push_back(mk(4'h0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0010, 1));
        vecs.push_back(mk(4'h5, 32'h1,        32'h24,       32'h00000010, 4'b0000, 1));
        vecs.push_back(mk(4'h7, 32'h5,        32'h5,        32'h0,        4'b1000, 1));
        vecs.push_back(mk(4'h8, 32'h0,        32'h12345,    32'h0,        4'b1000, 33));
        vecs.push_back(mk(4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        4'b0000, 33));
`ifdef ALU_DIV_EN
        vecs.push_back(mk(4'h9, 32'd100,      32'd7,        32'd14,       4'b0000, 33));
        vecs.push_back(mk(4'hA, 32'd100,      32'd7,        32'd2,        4'b0000, 33));
        vecs.push_back(mk(4'h9, 32'd5,        32'd0,        32'hFFFFFFFF, 4'b0001, 1));
        vecs.push_back(mk(4'hA, 32'd5,        32'd0,        32'd5,        4'b0001, 1));
        vecs.push_back(mk(4'hA, 32'd0,        32'd0,        32'd0,        4'b1001, 1));
`else
        vecs.push_back(mk(4'h9, 32'd100,      32'd7,        32'd0,        4'b1001, 1));
        vecs.push_back(mk(4'hA, 32'd100,      32'd7,        32'd0,        4'b1001, 1));
        vecs.push_back(mk(4'h9, 32'd5,        32'd0,        32'd0,        4'b1001, 1));
`endif

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_result",    64'(bus.aluresult), 64'd0);
        check("reset_flags",     64'({bus.zero, bus.carry, bus.ovf, bus.err}), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, flg, lat);
            $display("vec %0d op=%h a=%h b=%h -> res=%h flg=%b lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, res, flg, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
            check($sformatf("vec%0d_flags", i),  64'(flg), 64'(vecs[i].flg));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Reset asserted in BUSY cycle 5 of a multiply aborts it.
        bus.srca = 32'd7; bus.srcb = 32'd9; bus.alucontrol = 4'h8; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
        saw_valid = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw_valid++;
        end
        check("midreset_no_result", 64'(saw_valid), 64'd0);
        run_op(4'h0, 32'd1, 32'd1, res, flg, lat);
        $display("after reset add 1+1 -> res=%h lat=%0d", res, lat);
        check("midreset_add", 64'(res), 64'd2);

        // Multiply result held for 5 cycles with out_ready low; in_valid during DONE ignored.
        bus.srca = 32'h10000; bus.srcb = 32'h10001; bus.alucontrol = 4'h8; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.srca = 32'd3; bus.srcb = 32'd4; bus.alucontrol = 4'h0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("hold_latency", 64'(lat), 64'd33);
        hold_res = bus.aluresult;
        check("hold_result", 64'(hold_res), 64'h00010000);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", c),   64'(bus.aluresult), 64'h00010000);
            check($sformatf("hold%0d_valid", c),    64'(bus.out_valid), 64'd1);
            check($sformatf("hold%0d_in_ready", c), 64'(bus.in_ready),  64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        $display("hold mul -> res=%h lat=%0d", hold_res, lat);
        check("hold_release_valid", 64'(bus.out_valid), 64'd0);
        check("hold_release_ready", 64'(bus.in_ready),  64'd1);

        // Back-to-back single-cycle ops with out_ready tied high.
        accepts = 0;
        bus.out_ready = 1'b1;
        bus.srca = $urandom(); bus.srcb = $urandom(); bus.alucontrol = 4'($urandom_range(0, 7));
        bus.in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("b2b op=%h a=%h b=%h -> res=%h", e.op, e.a, e.b, bus.aluresult);
                    check("b2b_result", 64'(bus.aluresult), 64'(e.res));
                    check("b2b_flags", 64'({bus.zero, bus.carry, bus.ovf, bus.err}), 64'(e.flg));
                end
            end
            if (bus.in_ready) begin
                exp_q.push_back(model(bus.alucontrol, bus.srca, bus.srcb));
                accepts++;
            end
            @(posedge clk); #1;
            if (exp_q.size() != 0 && bus.out_valid == 1'b0) begin
                // operands changed only after they were taken
            end
            bus.srca = $urandom(); bus.srcb = $urandom(); bus.alucontrol = 4'($urandom_range(0, 7));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("b2b_accepts", 64'(accepts), 64'd10);
        check("b2b_leftover", 64'(exp_q.size()), 64'd0);

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            e  = model(op, a, b);
            run_op(op, a, b, res, flg, lat);
            $display("rnd %0d op=%h a=%h b=%h -> res=%h flg=%b lat=%0d", n, op, a, b, res, flg, lat);
            check("rnd_result",  64'(res), 64'(e.res));
            check("rnd_flags",   64'(flg), 64'(e.flg));
            check("rnd_latency", 64'(lat), 64'(e.lat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
